threefish_subkey_inject: RTL
============================

// Module: threefish_subkey_inject
// PURPOSE
//  Parametrised Threefish key-injection stage with an on-the-fly key schedule, for Threefish-256/512/1024.
//  Holds the cipher key and tweak, derives subkey s per block and adds it word-wise (encrypt) or subtracts it (decrypt).
//  Sits between the round datapath and the block I/O. Two-stage pipeline, valid/ready on both sides.
// PARAMETERS
//  NW     8                      64-bit words per block/key: 4, 8 or 16.
//  SW     5                      width of the subkey index s.
//  C240   64'h1BD11BDAA9FC1A22   key-schedule parity constant.
// PORTS
//  clk        in   1        clock, rising edge.
//  rst_n      in   1        asynchronous active-low reset.
//  key_load   in   1        load key_in/tweak_in this cycle.
//  key_in     in   NW*64    key; word i = bits [64*i+63:64*i].
//  tweak_in   in   128      t0 = [63:0], t1 = [127:64].
//  key_valid  out  1        a key has been loaded since reset.
//  in_valid   in   1        input block present.
//  in_ready   out  1        input accepted when in_valid & in_ready.
//  in_block   in   NW*64    state words, same packing as key_in.
//  in_s       in   SW       subkey index.
//  in_dec     in   1        0: add subkey, 1: subtract subkey.
//  out_valid  out  1        output block present.
//  out_ready  in   1        downstream accepts.
//  out_block  out  NW*64    injected block.
//  out_s      out  SW       in_s carried with the block.
// BEHAVIOUR
//  Reset (async on rst_n low): key_valid=0, out_valid=0, stage-1 valid=0, out_block=0, out_s=0, key/tweak regs=0.
//  Key load:
//  - key_load=1 registers k0..k(NW-1), t0, t1, kNW = C240 ^ k0 ^ ... ^ k(NW-1), t2 = t0 ^ t1.
//  - key_valid=1 from the next cycle on; key_load may be re-asserted at any time.
//  - in_ready=0 in any cycle with key_load=1; the new key applies to blocks accepted after that cycle.
//  - Blocks already inside the pipeline keep the subkey computed at acceptance.
//  Advance enable: en = !out_valid | out_ready.
//  in_ready = en & key_valid & !key_load.
//  Stage 1 (on en): capture block, s and dec; compute subkey words sk[i], all arithmetic mod 2^64:
//  - i < NW-3: sk[i] = k[(s+i) mod (NW+1)]
//  - i = NW-3: sk[i] = k[(s+NW-3) mod (NW+1)] + t[s mod 3]
//  - i = NW-2: sk[i] = k[(s+NW-2) mod (NW+1)] + t[(s+1) mod 3]
//  - i = NW-1: sk[i] = k[(s+NW-1) mod (NW+1)] + s, with s zero-extended to 64 bits.
//  Stage 2 (on en): out_block word i = block[i] + sk[i], or block[i] - sk[i] when dec=1.
//  - Carries and borrows never cross word boundaries.
//  - out_valid takes stage-1 valid; out_s follows the block.
//  Latency 2 cycles from acceptance to out_valid with no stall; throughput one block per cycle.
//  Stall (out_valid & !out_ready): both stages freeze and out_block/out_s stay stable; bubbles only fill, never drop.
//  Any in_s value is legal; the modulo wrap applies, with no range check.
//  Reset mid-operation flushes both stages; the key must be reloaded before in_ready rises again.
// TESTING
//  1 NW=8, key=0, tweak=0, s=0, enc, block=0x0..0 -> out_block=0 after 2 cycles; out_s=0.
//  2 Same key, s=1, block=0 -> word7 = 64'h1BD11BDAA9FC1A23, words 0..6 = 0.
//  3 key=0, t0=1, t1=2, s=0, block=0 -> word5=1, word6=2, all other words 0; s=1 -> word5=2, word6=3, word7=C240+1.
//  4 Random key/tweak/block, s=0..18, encrypt then feed output back with in_dec=1 -> original block restored; word-carry case: block word=FFFF..FF, sk=1 -> word=0, neighbour unchanged.
//  5 Stream 10 back-to-back blocks, out_ready toggled 1,0,0,1,...
//    -> all 10 emerge in order, none lost or duplicated; out_block held while stalled.
//  6 key_load during the stream, and rst_n low for 1 cycle mid-stream:
//    -> in_ready=0 in the load cycle; old-key blocks keep the old subkey;
//    -> after reset out_valid=0, key_valid=0, and in_ready stays 0 until the next key_load.

Source files
------------

// File: rtl/threefish_subkey_inject.sv
// Threefish key-injection stage: holds key/tweak, derives subkey s on the fly and
// adds (encrypt) or subtracts (decrypt) it word-wise over a two-stage pipeline.
module threefish_subkey_inject #(
    parameter int          NW   = 8,
    parameter int          SW   = 5,
    parameter logic [63:0] C240 = 64'h1BD11BDAA9FC1A22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic [NW*64-1:0] key_in,
    input  logic [127:0]     tweak_in,
    output logic             key_valid,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NW*64-1:0] in_block,
    input  logic [SW-1:0]    in_s,
    input  logic             in_dec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NW*64-1:0] out_block,
    output logic [SW-1:0]    out_s
);

    localparam int KW = NW + 1;
    localparam int IW = $clog2(KW);

    logic [63:0]      k_q [KW];
    logic [63:0]      t_q [3];
    logic [63:0]      k_par;
    logic [63:0]      sk [NW];
    logic             en;

    logic             s1_valid;
    logic [NW*64-1:0] s1_block;
    logic [SW-1:0]    s1_s;
    logic             s1_dec;
    logic [63:0]      s1_sk [NW];

    assign en       = !out_valid || out_ready;
    assign in_ready = en && key_valid && !key_load;

    // NOTE: every variable written in always_comb gets a default before any
    // conditional or loop update, so no latch can be inferred.
    always_comb begin
        k_par = C240;
        for (int i = 0; i < NW; i++) begin
            k_par = k_par ^ key_in[64*i +: 64];
        end
    end

    // NOTE: the extended key is a small register array, not a RAM, so it is
    // cleared on reset like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KW; i++) begin
                k_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                t_q[i] <= '0;
            end
            key_valid <= 1'b0;
        end else if (key_load) begin
            for (int i = 0; i < NW; i++) begin
                k_q[i] <= key_in[64*i +: 64];
            end
            k_q[NW]   <= k_par;
            t_q[0]    <= tweak_in[63:0];
            t_q[1]    <= tweak_in[127:64];
            t_q[2]    <= tweak_in[63:0] ^ tweak_in[127:64];
            key_valid <= 1'b1;
        end
    end

    // Subkey for in_s from the key currently held; in_ready is low in a load
    // cycle, so an accepted block never sees a half-updated key.
    always_comb begin
        int s_i;
        s_i = int'(in_s);
        for (int i = 0; i < NW; i++) begin
            sk[i] = k_q[IW'((s_i + i) % KW)];
        end
        sk[NW-3] = sk[NW-3] + t_q[2'(s_i % 3)];
        sk[NW-2] = sk[NW-2] + t_q[2'((s_i + 1) % 3)];
        sk[NW-1] = sk[NW-1] + 64'(in_s);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_block <= '0;
            s1_s     <= '0;
            s1_dec   <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                s1_sk[i] <= '0;
            end
        end else if (en) begin
            s1_valid <= in_valid && in_ready;
            s1_block <= in_block;
            s1_s     <= in_s;
            s1_dec   <= in_dec;
            for (int i = 0; i < NW; i++) begin
                s1_sk[i] <= sk[i];
            end
        end
    end

    // Word-sliced add/sub keeps carries and borrows inside each 64-bit lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_block <= '0;
            out_s     <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            out_s     <= s1_s;
            for (int i = 0; i < NW; i++) begin
                out_block[64*i +: 64] <= s1_dec ? s1_block[64*i +: 64] - s1_sk[i]
                                                : s1_block[64*i +: 64] + s1_sk[i];
            end
        end
    end

endmodule
